// File: rtl/bec_seq_ctrl.sv
// bec_seq_ctrl: host-side sequencer for a big-operand compute core.
// Streams 2*WORDS operand words into the core, starts it, watches for
// completion with a timeout watchdog, and serves result words back to the host.
module bec_seq_ctrl #(
    parameter int WORDS = 6,
    parameter int TMO   = 4095
) (
    input  logic                           wb_clk_i,
    input  logic                           wb_rst_i,
    input  logic                           host_valid,
    output logic                           host_ready,
    input  logic [1:0]                     host_op,
    input  logic [31:0]                    host_wdata,
    output logic [31:0]                    host_rdata,
    output logic                           host_rvalid,
    output logic [3:0]                     status,
    output logic                           irq,
    output logic                           core_wr_en,
    output logic [$clog2(2*WORDS)-1:0]     core_wr_addr,
    output logic [31:0]                    core_wr_data,
    output logic                           core_start,
    input  logic                           core_done,
    output logic [$clog2(WORDS)-1:0]       core_rd_addr,
    input  logic [31:0]                    core_rd_data
);

    localparam int AW = $clog2(2*WORDS);
    localparam int RW = $clog2(WORDS);
    localparam int PW = $clog2(2*WORDS+1);   // wptr must be able to hold 2*WORDS
    localparam int CW = $clog2(TMO+1);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_START = 2'b01;
    localparam logic [1:0] OP_READ  = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic [1:0] {IDLE, WAIT, DONE, ERR} state_t;

    state_t          state_q, state_d;
    logic [PW-1:0]   wptr_q, wptr_d;
    logic [RW-1:0]   rptr_q, rptr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            done_q, done_d;
    logic            eseq_q, eseq_d;
    logic            etmo_q, etmo_d;
    logic            wr_en_q, wr_en_d;
    logic [AW-1:0]   wr_addr_q, wr_addr_d;
    logic [31:0]     wr_data_q, wr_data_d;
    logic            start_q, start_d;
    logic            irq_q, irq_d;
    logic            rvalid_q, rvalid_d;
    logic            rdbusy_q, rdbusy_d;   // blocks the host for one cycle after any READ
    logic            acc;
    logic            full;
    logic            clr;

    assign acc  = host_valid && host_ready;
    assign full = (wptr_q == PW'(2*WORDS));

    // Next-state and output decode; every target defaults to hold or idle first
    always_comb begin
        state_d   = state_q;
        wptr_d    = wptr_q;
        rptr_d    = rptr_q;
        cnt_d     = cnt_q;
        done_d    = done_q;
        eseq_d    = eseq_q;
        etmo_d    = etmo_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        start_d   = 1'b0;
        irq_d     = 1'b0;
        rvalid_d  = 1'b0;
        rdbusy_d  = 1'b0;
        clr       = 1'b0;

        case (state_q)
            IDLE: if (acc) begin
                case (host_op)
                    OP_LOAD: begin
                        if (!full) begin
                            wr_en_d   = 1'b1;
                            wr_addr_d = wptr_q[AW-1:0];
                            wr_data_d = host_wdata;
                            wptr_d    = wptr_q + PW'(1);
                        end else begin
                            eseq_d = 1'b1;
                        end
                    end
                    OP_START: begin
                        if (full) begin
                            start_d = 1'b1;
                            cnt_d   = '0;
                            state_d = WAIT;
                        end else begin
                            eseq_d = 1'b1;
                        end
                    end
                    OP_READ: begin
                        eseq_d   = 1'b1;
                        rdbusy_d = 1'b1;
                    end
                    default: clr = 1'b1;
                endcase
            end
            WAIT: begin
                // completion wins over a timeout landing in the same cycle
                if (core_done) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                    rptr_d  = '0;
                    cnt_d   = '0;
                    irq_d   = 1'b1;
                end else if (cnt_q == CW'(TMO-1)) begin
                    state_d = ERR;
                    etmo_d  = 1'b1;
                    irq_d   = 1'b1;
                    cnt_d   = CW'(TMO);
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: if (acc) begin
                case (host_op)
                    OP_READ: begin
                        // core samples rptr at this edge; data returns next cycle
                        rvalid_d = 1'b1;
                        rdbusy_d = 1'b1;
                        rptr_d   = (rptr_q == RW'(WORDS-1)) ? '0 : rptr_q + RW'(1);
                    end
                    OP_CLEAR: clr = 1'b1;
                    default:  eseq_d = 1'b1;
                endcase
            end
            default: if (acc) begin   // ERR
                case (host_op)
                    OP_CLEAR: clr = 1'b1;
                    OP_READ: begin
                        eseq_d   = 1'b1;
                        rdbusy_d = 1'b1;
                    end
                    default:  eseq_d = 1'b1;
                endcase
            end
        endcase

        if (clr) begin
            state_d = IDLE;
            wptr_d  = '0;
            rptr_d  = '0;
            cnt_d   = '0;
            done_d  = 1'b0;
            eseq_d  = 1'b0;
            etmo_d  = 1'b0;
        end
    end

    // State, pointer, flag and registered-output update with synchronous reset
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q   <= IDLE;
            wptr_q    <= '0;
            rptr_q    <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
            eseq_q    <= 1'b0;
            etmo_q    <= 1'b0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            start_q   <= 1'b0;
            irq_q     <= 1'b0;
            rvalid_q  <= 1'b0;
            rdbusy_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            wptr_q    <= wptr_d;
            rptr_q    <= rptr_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            eseq_q    <= eseq_d;
            etmo_q    <= etmo_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            start_q   <= start_d;
            irq_q     <= irq_d;
            rvalid_q  <= rvalid_d;
            rdbusy_q  <= rdbusy_d;
        end
    end

    assign host_ready   = (state_q != WAIT) && !rdbusy_q;
    assign host_rvalid  = rvalid_q;
    assign host_rdata   = rvalid_q ? core_rd_data : 32'h0;
    assign status       = {etmo_q, eseq_q, done_q, state_q == WAIT};
    assign irq          = irq_q;
    assign core_wr_en   = wr_en_q;
    assign core_wr_addr = wr_addr_q;
    assign core_wr_data = wr_data_q;
    assign core_start   = start_q;
    assign core_rd_addr = rptr_q;

endmodule

// File: tb/tb_bec_seq_ctrl.sv
// Randomized self-checking bench for bec_seq_ctrl against a small host/core model.
module tb_bec_seq_ctrl;
    localparam int WORDS = 6;
    localparam int TMO   = 4095;
    localparam int AW    = $clog2(2*WORDS);
    localparam int RW    = $clog2(WORDS);

    logic            wb_clk_i = 1'b0;
    logic            wb_rst_i = 1'b1;
    logic            host_valid = 1'b0;
    logic            host_ready;
    logic [1:0]      host_op = 2'b00;
    logic [31:0]     host_wdata = '0;
    logic [31:0]     host_rdata;
    logic            host_rvalid;
    logic [3:0]      status;
    logic            irq;
    logic            core_wr_en;
    logic [AW-1:0]   core_wr_addr;
    logic [31:0]     core_wr_data;
    logic            core_start;
    logic            core_done = 1'b0;
    logic [RW-1:0]   core_rd_addr;
    logic [31:0]     core_rd_data = '0;

    int n_chk = 0;
    int n_fail = 0;

    // observed-event logs, written only by the monitor
    logic [AW-1:0]   wa_log[$];
    logic [31:0]     wd_log[$];
    logic [31:0]     rd_log[$];
    int              start_cnt = 0;
    int              irq_cnt = 0;
    int              busy_cnt = 0;

    logic [31:0]     rmem [WORDS];   // core result memory model
    logic [31:0]     words[$];       // operand words the host intends to load

    bec_seq_ctrl #(.WORDS(WORDS), .TMO(TMO)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .host_valid(host_valid), .host_ready(host_ready), .host_op(host_op),
        .host_wdata(host_wdata), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
        .status(status), .irq(irq),
        .core_wr_en(core_wr_en), .core_wr_addr(core_wr_addr), .core_wr_data(core_wr_data),
        .core_start(core_start), .core_done(core_done),
        .core_rd_addr(core_rd_addr), .core_rd_data(core_rd_data)
    );

    always #5 wb_clk_i = ~wb_clk_i;

    // synchronous-read result memory of the core
    always @(posedge wb_clk_i) core_rd_data <= rmem[core_rd_addr];

    // sample DUT outputs mid-cycle
    always @(negedge wb_clk_i) begin
        if (core_wr_en === 1'b1) begin
            wa_log.push_back(core_wr_addr);
            wd_log.push_back(core_wr_data);
        end
        if (core_start === 1'b1) start_cnt++;
        if (irq === 1'b1) irq_cnt++;
        if (host_rvalid === 1'b1) rd_log.push_back(host_rdata);
        if (status[0] === 1'b1) busy_cnt++;
    end

    task automatic idle(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1;
    endtask

    task automatic send(input logic [1:0] op, input logic [31:0] d);
        int w = 0;
        @(negedge wb_clk_i);
        while (host_ready !== 1'b1 && w < 100) begin
            @(negedge wb_clk_i);
            w++;
        end
        n_chk++;
        if (host_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL send_ready: host_ready=%b after %0d cycles, required 1", host_ready, w);
        end
        host_valid = 1'b1;
        host_op    = op;
        host_wdata = d;
        @(posedge wb_clk_i);
        #1 host_valid = 1'b0;
    endtask

    task automatic pulse_done_after(input int n);
        repeat (n) @(posedge wb_clk_i);
        #1 core_done = 1'b1;
        @(posedge wb_clk_i);
        #1 core_done = 1'b0;
    endtask

    task automatic load_words(input int n);
        for (int i = 0; i < n; i++) send(2'b00, words[i]);
        idle(2);
    endtask

    task automatic fill_words(input bit rnd);
        words.delete();
        for (int i = 0; i < 2*WORDS; i++) words.push_back(rnd ? $urandom : 32'h1000 + i);
    endtask

    task automatic test_reset;
        wb_rst_i = 1'b1;
        idle(2);
        wb_rst_i = 1'b0;
        @(negedge wb_clk_i);
        n_chk++; if (status !== 4'b0000) begin n_fail++; $display("FAIL rst_status: got %b exp 0000", status); end
        n_chk++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rst_ready: got %b exp 1", host_ready); end
        n_chk++; if ({host_rvalid, irq, core_wr_en, core_start} !== 4'b0) begin n_fail++; $display("FAIL rst_strobes: got %b exp 0000", {host_rvalid, irq, core_wr_en, core_start}); end
        n_chk++; if (host_rdata !== 32'h0) begin n_fail++; $display("FAIL rst_rdata: got %h exp 0", host_rdata); end
        n_chk++; if (core_wr_addr !== '0 || core_wr_data !== 32'h0) begin n_fail++; $display("FAIL rst_wr: got %h/%h exp 0/0", core_wr_addr, core_wr_data); end
        n_chk++; if (core_rd_addr !== '0) begin n_fail++; $display("FAIL rst_rd_addr: got %h exp 0", core_rd_addr); end
    endtask

    // full load, start, completion after dly cycles; checks writes, start, irq, WAIT length
    task automatic run_op(input string nm, input int dly);
        int wb, sb, ib, bb;
        send(2'b11, 0);
        wb = wa_log.size();
        load_words(2*WORDS);
        n_chk++; if (wa_log.size() != wb + 2*WORDS) begin n_fail++; $display("FAIL %s_wr_count: got %0d exp %0d", nm, wa_log.size() - wb, 2*WORDS); end
        for (int i = 0; i < 2*WORDS && wb + i < wa_log.size(); i++) begin
            n_chk++;
            if (wa_log[wb+i] !== AW'(i) || wd_log[wb+i] !== words[i]) begin
                n_fail++;
                $display("FAIL %s_wr[%0d]: got %0d/%h exp %0d/%h", nm, i, wa_log[wb+i], wd_log[wb+i], i, words[i]);
            end
        end
        sb = start_cnt; ib = irq_cnt; bb = busy_cnt;
        send(2'b01, 0);
        pulse_done_after(dly);
        idle(3);
        n_chk++; if (start_cnt != sb + 1) begin n_fail++; $display("FAIL %s_start: got %0d pulses exp 1", nm, start_cnt - sb); end
        n_chk++; if (irq_cnt != ib + 1) begin n_fail++; $display("FAIL %s_irq: got %0d pulses exp 1", nm, irq_cnt - ib); end
        n_chk++; if (busy_cnt != bb + dly + 1) begin n_fail++; $display("FAIL %s_wait_len: got %0d exp %0d", nm, busy_cnt - bb, dly + 1); end
        n_chk++; if (status !== 4'b0010) begin n_fail++; $display("FAIL %s_status: got %b exp 0010", nm, status); end
    endtask

    task automatic do_reads(input string nm, input int n);
        int rb = rd_log.size();
        for (int k = 0; k < n; k++) send(2'b10, 0);
        idle(2);
        n_chk++; if (rd_log.size() != rb + n) begin n_fail++; $display("FAIL %s_rvalid_count: got %0d exp %0d", nm, rd_log.size() - rb, n); end
        for (int k = 0; k < n && rb + k < rd_log.size(); k++) begin
            n_chk++;
            if (rd_log[rb+k] !== rmem[k % WORDS]) begin
                n_fail++;
                $display("FAIL %s_rdata[%0d]: got %h exp %h", nm, k, rd_log[rb+k], rmem[k % WORDS]);
            end
        end
    endtask

    task automatic test_load_start;
        fill_words(0);
        run_op("load", 20);
    endtask

    task automatic test_read;
        for (int i = 0; i < WORDS; i++) rmem[i] = 32'hA0 + i;
        do_reads("read", 7);
        n_chk++; if (status !== 4'b0010) begin n_fail++; $display("FAIL read_status: got %b exp 0010", status); end
    endtask

    task automatic test_seq_err;
        int sb, rb, wb;
        send(2'b11, 0);
        idle(1);
        n_chk++; if (status !== 4'b0000) begin n_fail++; $display("FAIL clr_status: got %b exp 0000", status); end
        fill_words(1);
        load_words(5);
        sb = start_cnt;
        send(2'b01, 0);
        idle(3);
        n_chk++; if (start_cnt != sb) begin n_fail++; $display("FAIL early_start_pulse: got %0d exp 0", start_cnt - sb); end
        n_chk++; if (status !== 4'b0100) begin n_fail++; $display("FAIL early_start_status: got %b exp 0100", status); end
        rb = rd_log.size();
        send(2'b10, 0);
        idle(2);
        n_chk++; if (rd_log.size() != rb) begin n_fail++; $display("FAIL idle_read_rvalid: got %0d exp 0", rd_log.size() - rb); end
        send(2'b11, 0);
        load_words(2*WORDS);
        n_chk++; if (status !== 4'b0000) begin n_fail++; $display("FAIL full_load_status: got %b exp 0000", status); end
        wb = wa_log.size();
        send(2'b00, 32'hDEAD_BEEF);
        idle(2);
        n_chk++; if (wa_log.size() != wb) begin n_fail++; $display("FAIL overflow_write: got %0d writes exp 0", wa_log.size() - wb); end
        n_chk++; if (status !== 4'b0100) begin n_fail++; $display("FAIL overflow_status: got %b exp 0100", status); end
    endtask

    task automatic test_done_errs;
        int wb, sb;
        fill_words(1);
        run_op("done_err", 3);
        wb = wa_log.size(); sb = start_cnt;
        send(2'b00, 32'h1234);
        send(2'b01, 0);
        idle(3);
        n_chk++; if (wa_log.size() != wb || start_cnt != sb) begin n_fail++; $display("FAIL done_cmds_side_effect: got %0d writes %0d starts exp 0 0", wa_log.size() - wb, start_cnt - sb); end
        n_chk++; if (status !== 4'b0110) begin n_fail++; $display("FAIL done_cmds_status: got %b exp 0110", status); end
    endtask

    task automatic test_timeout;
        int ib, bb, w, rb;
        send(2'b11, 0);
        fill_words(1);
        load_words(2*WORDS);
        ib = irq_cnt; bb = busy_cnt; w = 0;
        send(2'b01, 0);
        while (irq_cnt == ib && w < TMO + 100) begin
            @(posedge wb_clk_i);
            w++;
        end
        idle(2);
        n_chk++; if (irq_cnt != ib + 1) begin n_fail++; $display("FAIL tmo_irq: got %0d pulses exp 1", irq_cnt - ib); end
        n_chk++; if (busy_cnt != bb + TMO) begin n_fail++; $display("FAIL tmo_wait_len: got %0d exp %0d", busy_cnt - bb, TMO); end
        n_chk++; if (status !== 4'b1000) begin n_fail++; $display("FAIL tmo_status: got %b exp 1000", status); end
        pulse_done_after(1);
        idle(2);
        n_chk++; if (status !== 4'b1000 || irq_cnt != ib + 1) begin n_fail++; $display("FAIL err_ignores_done: got %b/%0d exp 1000/1", status, irq_cnt - ib); end
        rb = rd_log.size();
        send(2'b10, 0);
        idle(2);
        n_chk++; if (rd_log.size() != rb || status !== 4'b1100) begin n_fail++; $display("FAIL err_read: got %0d rvalid %b exp 0 1100", rd_log.size() - rb, status); end
        send(2'b11, 0);
        idle(1);
        n_chk++; if (status !== 4'b0000) begin n_fail++; $display("FAIL tmo_clear: got %b exp 0000", status); end
    endtask

    task automatic test_done_at_tmo;
        fill_words(1);
        run_op("edge_tmo", TMO - 1);
    endtask

    task automatic test_reset_mid_wait;
        int ib;
        send(2'b11, 0);
        fill_words(1);
        load_words(2*WORDS);
        send(2'b01, 0);
        idle(10);
        ib = irq_cnt;
        wb_rst_i = 1'b1;
        idle(1);
        wb_rst_i = 1'b0;
        pulse_done_after(2);
        idle(3);
        n_chk++; if (status !== 4'b0000) begin n_fail++; $display("FAIL rstwait_status: got %b exp 0000", status); end
        n_chk++; if (irq_cnt != ib) begin n_fail++; $display("FAIL rstwait_irq: got %0d pulses exp 0", irq_cnt - ib); end
        n_chk++; if (host_ready !== 1'b1) begin n_fail++; $display("FAIL rstwait_ready: got %b exp 1", host_ready); end
    endtask

    task automatic test_random;
        for (int r = 0; r < 4; r++) begin
            fill_words(1);
            run_op("rand", $urandom_range(0, 60));
            for (int i = 0; i < WORDS; i++) rmem[i] = $urandom;
            do_reads("rand", $urandom_range(1, 10));
        end
    endtask

    initial begin
        for (int i = 0; i < WORDS; i++) rmem[i] = '0;
        test_reset;
        test_load_start;
        test_read;
        test_seq_err;
        test_done_errs;
        test_timeout;
        test_done_at_tmo;
        test_reset_mid_wait;
        test_random;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
